// File: rtl/if1_fetch_pc_gen.sv
// IF1 PC generation and IF2 alignment register: issues 8-byte aligned ICache
// fetches and presents one or two PC/IR pairs to the instruction buffer.
module if1_fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_BR,
    input  logic [31:0] i_br_target,
    input  logic        stall_ICache,
    input  logic        i_is_full,
    input  logic [63:0] i_rdata,
    output logic        o_fetch_req,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_PC1,
    output logic [31:0] o_IR1,
    output logic [31:0] o_PC2,
    output logic [31:0] o_IR2,
    output logic [1:0]  o_is_valid
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH_WAIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc2_q, pc2_d;
    logic        valid2_q, valid2_d;
    logic [31:0] next_pc;

    // An upper-half start address yields a single-instruction group.
    assign next_pc     = pc_q + (pc_q[2] ? 32'd4 : 32'd8);
    assign o_fetch_req = (state_q == RUN) & ~i_is_full & ~flush_BR;
    assign o_fetch_pc  = {pc_q[31:3], 3'b000};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc2_d    = pc2_q;
        valid2_d = valid2_q;
        if (flush_BR) begin
            pc_d     = {i_br_target[31:2], 2'b00};
            valid2_d = 1'b0;
            state_d  = stall_ICache ? FLUSH_WAIT : RUN;
        end else if (!stall_ICache) begin
            // The held group is consumed this cycle; keep valid only on a new request.
            valid2_d = o_fetch_req;
            pc2_d    = pc_q;
            state_d  = RUN;
            if (o_fetch_req) pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            pc2_q    <= 32'd0;
            valid2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc2_q    <= pc2_d;
            valid2_q <= valid2_d;
        end
    end

    always_comb begin
        o_PC1      = 32'd0;
        o_PC2      = 32'd0;
        o_IR1      = 32'd0;
        o_IR2      = 32'd0;
        o_is_valid = 2'b00;
        if (valid2_q) begin
            o_PC1 = pc2_q;
            o_PC2 = pc2_q + 32'd4;
            if (pc2_q[2]) begin
                o_IR1      = i_rdata[63:32];
                o_is_valid = 2'b10;
            end else begin
                o_IR1      = i_rdata[31:0];
                o_IR2      = i_rdata[63:32];
                o_is_valid = 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_if1_fetch_pc_gen.sv
// Bench for if1_fetch_pc_gen: two instances (default and wrap-around reset PC)
// driven in lockstep and compared against a transaction-level model.
module tb_if1_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst, flush_BR, stall_ICache, i_is_full;
    logic [31:0] i_br_target;
    logic [63:0] i_rdata;

    logic        req  [2];
    logic [31:0] fpc  [2];
    logic [31:0] pc1  [2];
    logic [31:0] ir1  [2];
    logic [31:0] pc2  [2];
    logic [31:0] ir2  [2];
    logic [1:0]  vld  [2];

    int checks = 0;
    int fails  = 0;

    // Model: phase 0=booting, 1=fetching, 2=waiting out a stalled redirect.
    int          m_ph     [2];
    logic [31:0] m_pc     [2];
    bit          m_pend   [2];
    logic [31:0] m_ppc    [2];
    logic [31:0] m_stream [2];

    always #5 clk = ~clk;

    if1_fetch_pc_gen u0 (
        .clk(clk), .rst(rst), .flush_BR(flush_BR), .i_br_target(i_br_target),
        .stall_ICache(stall_ICache), .i_is_full(i_is_full), .i_rdata(i_rdata),
        .o_fetch_req(req[0]), .o_fetch_pc(fpc[0]), .o_PC1(pc1[0]), .o_IR1(ir1[0]),
        .o_PC2(pc2[0]), .o_IR2(ir2[0]), .o_is_valid(vld[0]));

    if1_fetch_pc_gen #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst(rst), .flush_BR(flush_BR), .i_br_target(i_br_target),
        .stall_ICache(stall_ICache), .i_is_full(i_is_full), .i_rdata(i_rdata),
        .o_fetch_req(req[1]), .o_fetch_pc(fpc[1]), .o_PC1(pc1[1]), .o_IR1(ir1[1]),
        .o_PC2(pc2[1]), .o_IR2(ir2[1]), .o_is_valid(vld[1]));

    function automatic logic [31:0] rpc(int k);
        return (k == 0) ? 32'h1C00_0000 : 32'hFFFF_FFF8;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic        e_req;
            logic [1:0]  e_vld;
            logic [31:0] e_pc1, e_pc2, e_ir1, e_ir2;
            e_req = (m_ph[k] == 1) && !i_is_full && !flush_BR;
            e_vld = 2'b00; e_pc1 = 0; e_pc2 = 0; e_ir1 = 0; e_ir2 = 0;
            if (m_pend[k]) begin
                e_pc1 = m_ppc[k];
                e_pc2 = m_ppc[k] + 32'd4;
                if (m_ppc[k][2]) begin
                    e_vld = 2'b10; e_ir1 = i_rdata[63:32];
                end else begin
                    e_vld = 2'b11; e_ir1 = i_rdata[31:0]; e_ir2 = i_rdata[63:32];
                end
            end
            chk($sformatf("req%0d", k), 64'(req[k]), 64'(e_req));
            chk($sformatf("fetch_pc%0d", k), 64'(fpc[k]), 64'(m_pc[k] & ~32'd7));
            chk($sformatf("valid%0d", k), 64'(vld[k]), 64'(e_vld));
            chk($sformatf("pc1_%0d", k), 64'(pc1[k]), 64'(e_pc1));
            chk($sformatf("pc2_%0d", k), 64'(pc2[k]), 64'(e_pc2));
            chk($sformatf("ir1_%0d", k), 64'(ir1[k]), 64'(e_ir1));
            chk($sformatf("ir2_%0d", k), 64'(ir2[k]), 64'(e_ir2));
            // Delivered instruction stream must be contiguous: no skips, no repeats.
            if (vld[k] != 2'b00 && !stall_ICache) begin
                chk($sformatf("stream%0d", k), 64'(pc1[k]), 64'(m_stream[k]));
                m_stream[k] = m_stream[k] + ((vld[k] == 2'b11) ? 32'd8 : 32'd4);
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ph[k] = 0; m_pc[k] = rpc(k); m_pend[k] = 0; m_ppc[k] = 0;
                m_stream[k] = rpc(k);
            end else if (flush_BR) begin
                m_pc[k] = i_br_target & ~32'd3; m_pend[k] = 0;
                m_ph[k] = stall_ICache ? 2 : 1;
                m_stream[k] = i_br_target & ~32'd3;
            end else if (!stall_ICache) begin
                bit fetch;
                fetch = (m_ph[k] == 1) && !i_is_full;
                m_pend[k] = fetch;
                m_ppc[k]  = m_pc[k];
                if (fetch) m_pc[k] = m_pc[k] + (m_pc[k][2] ? 32'd4 : 32'd8);
                m_ph[k] = 1;
            end
        end
    endtask

    task automatic drive(bit r, bit f, logic [31:0] t, bit s, bit full);
        rst = r; flush_BR = f; i_br_target = t; stall_ICache = s; i_is_full = full;
        i_rdata = {$urandom(), $urandom()};
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [31:0] frozen_pc;
        logic [63:0] rd;
        drive(1, 0, 0, 0, 0);
        @(posedge clk); model_edge(); #1;
        drive(1, 0, 0, 0, 0);
        chk("rst_req", 64'(req[0]), 64'd0);
        chk("rst_valid", 64'(vld[0]), 64'd0);
        step();

        // Reset release and idle streaming
        drive(0, 0, 0, 0, 0);
        chk("boot_req", 64'(req[0]), 64'd0);
        chk("boot_pc", 64'(fpc[0]), 64'h1C00_0000);
        step();
        drive(0, 0, 0, 0, 0);
        chk("first_req", 64'(req[0]), 64'd1);
        chk("first_pc", 64'(fpc[0]), 64'h1C00_0000);
        step();
        drive(0, 0, 0, 0, 0);
        chk("seq_pc8", 64'(fpc[0]), 64'h1C00_0008);
        chk("seq_valid", 64'(vld[0]), 64'h3);
        chk("seq_pc1", 64'(pc1[0]), 64'h1C00_0000);
        chk("seq_pc2", 64'(pc2[0]), 64'h1C00_0004);
        chk("wrap_pc", 64'(fpc[1]), 64'h0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("seq_pc10", 64'(fpc[0]), 64'h1C00_0010);
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 0); step(); end

        // Redirect to an upper-half target
        drive(0, 1, 32'h1C00_0104, 0, 0);
        chk("flush_req", 64'(req[0]), 64'd0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("flush_fpc", 64'(fpc[0]), 64'h1C00_0100);
        step();
        drive(0, 0, 0, 0, 0);
        rd = i_rdata;
        chk("flush_valid", 64'(vld[0]), 64'h2);
        chk("flush_pc1", 64'(pc1[0]), 64'h1C00_0104);
        chk("flush_ir1", 64'(ir1[0]), 64'(rd[63:32]));
        chk("flush_next", 64'(fpc[0]), 64'h1C00_0108);
        step();
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0); step(); end

        // Stall mid-stream
        frozen_pc = fpc[0];
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("stall_fpc", 64'(fpc[0]), 64'(frozen_pc));
            step();
        end
        for (int i = 0; i < 20; i++) begin drive(0, 0, 0, 0, 0); step(); end

        // Redirect while stalled
        drive(0, 1, 32'h1C00_2000, 1, 0); step();
        drive(0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        chk("fw_valid", 64'(vld[0]), 64'd0);
        chk("fw_req", 64'(req[0]), 64'd0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("fw_fpc", 64'(fpc[0]), 64'h1C00_2000);
        chk("fw_req2", 64'(req[0]), 64'd1);
        step();
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0); step(); end

        // Buffer full back-pressure
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            chk("full_req", 64'(req[0]), 64'd0);
            if (i > 0) chk("full_valid", 64'(vld[0]), 64'd0);
            step();
        end
        for (int i = 0; i < 6; i++) begin drive(0, 0, 0, 0, 0); step(); end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 6, $urandom(),
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20);
            step();
        end

        // Reset while stalled returns via BOOT
        drive(0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        drive(1, 1, 32'h1234_5678, 1, 0); step();
        drive(0, 0, 0, 1, 0);
        chk("rst_stall_fpc", 64'(fpc[1]), 64'hFFFF_FFF8);
        chk("rst_stall_req", 64'(req[1]), 64'd0);
        step();
        drive(0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        chk("rst_run_req", 64'(req[1]), 64'd1);
        chk("rst_run_fpc", 64'(fpc[1]), 64'hFFFF_FFF8);
        step();
        drive(0, 0, 0, 0, 0);
        chk("rst_wrap", 64'(fpc[1]), 64'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
